stack_ctl: RTL and testbench
============================

STACK_CTL -- requirements
Module: stack_ctl

Interface
REQ-001 Parameter DEPTH, default 18, tail entries of the attached 16-bit stack; capacity CAP = DEPTH+1 (head plus tail).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-006 cmd_op  input  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE.
REQ-007 cmd_data  input  16  PUSH/REPLACE value.
REQ-008 rsp_valid  output  1  POP result available.
REQ-009 rsp_ready  input  1  consumer takes the result.
REQ-010 rsp_data  output  16  popped value.
REQ-011 rsp_err  output  1  popped value invalid (underflow).
REQ-012 st_we, st_delta[1:0], st_wd[15:0]  output  stack strobes; st_rd[15:0]  input  stack head.
REQ-013 depth  output  5  current occupancy 0..CAP.
REQ-014 hwm  output  5  high-water mark of depth.
REQ-015 err_over, err_under  output  1 each  sticky error flags; err_clr  input  1  clears them.

Function
REQ-016 cmd_ready SHALL be (!rsp_valid || rsp_ready), combinational.
REQ-017 Strobes SHALL be combinational from the accepted command, zero when no command is accepted: PUSH we=1 delta=01 wd=cmd_data; POP we=0 delta=11; REPLACE we=1 delta=00 wd=cmd_data; NOP all zero.
REQ-018 Accepted PUSH SHALL increment depth on the next edge; POP SHALL decrement it; REPLACE and NOP leave it unchanged.
REQ-019 Accepted POP SHALL register rsp_data <= st_rd and set rsp_valid on the same edge (latency 1).
REQ-020 rsp_valid SHALL hold rsp_data/rsp_err stable until the edge where rsp_ready is high; with no new POP that edge clears rsp_valid.
REQ-021 A POP accepted on the same edge as the rsp_ready handshake SHALL load the new result, and rsp_valid SHALL stay high.
REQ-022 Handshake state SHALL be two-state, EMPTY (rsp_valid=0) and FULL (rsp_valid=1): EMPTY->FULL on POP accept; FULL->EMPTY on rsp_ready without POP accept; FULL->FULL otherwise.
REQ-023 PUSH at depth==CAP SHALL set err_over; POP or REPLACE at depth==0 SHALL set err_under.
REQ-024 POP at depth==0 SHALL return rsp_data=16'h0000 with rsp_err=1; otherwise rsp_err=0.
REQ-025 depth SHALL saturate at 0 and CAP, never wrapping.
REQ-026 hwm SHALL update to the next depth whenever that value exceeds hwm.
REQ-027 err_clr SHALL clear err_over/err_under and set hwm to the current depth. A new error in the same cycle takes priority and sets its flag.

Reset
REQ-028 On reset: depth=0, hwm=0, err_over=0, err_under=0, rsp_valid=0, rsp_data=0, rsp_err=0. Strobes SHALL be forced to zero during the reset cycle regardless of cmd_valid.
REQ-029 Reset mid-response SHALL discard the pending result. The stack contents are not cleared, but depth=0 defines them as empty.

Configuration
REQ-030 Macro STACK_GUARD_EN. When defined, an overflowing PUSH and an underflowing POP/REPLACE SHALL be accepted but SHALL produce all-zero strobes, so the stack is untouched.
REQ-031 Without STACK_GUARD_EN, those commands SHALL drive strobes per REQ-017. Flags, saturation and rsp_err still behave per REQ-023..025.

Verification
REQ-032 Reset, then PUSH 0x1111, 0x2222, 0x3333 -> depth=3, hwm=3, st_we/st_delta=1/01 on each accept cycle.
REQ-033 Then POP with rsp_ready=1 -> rsp_data=0x3333 one cycle later, rsp_err=0, depth=2.
REQ-034 POP with rsp_ready=0 for 3 cycles -> rsp_valid held and cmd_ready=0. Raising rsp_ready with a concurrent POP -> new result 0x1111 loaded and rsp_valid stays 1.
REQ-035 From depth=0: POP -> rsp_data=0x0000, rsp_err=1, err_under=1, depth=0. With STACK_GUARD_EN the strobes are zero; without it, st_delta=11.
REQ-036 Push CAP+1 (=20) values -> depth=19, err_over=1, hwm=19. Then err_clr -> flags 0, hwm=19. The 20th push produces zero strobes only with STACK_GUARD_EN.
REQ-037 Assert reset while rsp_valid=1 and depth=5 -> next cycle rsp_valid=0, depth=0, hwm=0, and no strobes during the reset cycle.

Source files
------------

// File: rtl/stack_ctl.sv
// Command/response controller for an external 16-bit stack (head register + DEPTH tail entries).
// Optional build macro STACK_GUARD_EN: overflowing/underflowing commands are accepted but leave the stack untouched.
module stack_ctl #(
    parameter int DEPTH = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        st_we,
    output logic [1:0]  st_delta,
    output logic [15:0] st_wd,
    input  logic [15:0] st_rd,
    output logic [4:0]  depth,
    output logic [4:0]  hwm,
    output logic        err_over,
    output logic        err_under,
    input  logic        err_clr
);

    localparam logic [4:0] CAP = 5'(DEPTH + 1);

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e state_q, state_d;
    op_e        op;
    logic       accept;
    logic       is_push, is_pop, is_repl;
    logic       overflow, underflow, blocked;
    logic [4:0] depth_nxt;
    logic [4:0] hwm_base;

    assign op        = op_e'(cmd_op);
    assign rsp_valid = (state_q == RSP_FULL);
    assign cmd_ready = !rsp_valid || rsp_ready;
    assign accept    = cmd_valid && cmd_ready && !reset;

    assign is_push   = accept && (op == OP_PUSH);
    assign is_pop    = accept && (op == OP_POP);
    assign is_repl   = accept && (op == OP_REPLACE);
    assign overflow  = is_push && (depth == CAP);
    assign underflow = (is_pop || is_repl) && (depth == '0);

`ifdef STACK_GUARD_EN
    assign blocked = overflow || underflow;
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        st_we    = 1'b0;
        st_delta = 2'b00;
        st_wd    = '0;
        if (accept && !blocked) begin
            case (op)
                OP_PUSH: begin
                    st_we    = 1'b1;
                    st_delta = 2'b01;
                    st_wd    = cmd_data;
                end
                OP_POP: begin
                    st_delta = 2'b11;
                end
                OP_REPLACE: begin
                    st_we    = 1'b1;
                    st_wd    = cmd_data;
                end
                default: ;
            endcase
        end
    end

    // Occupancy saturates at both ends regardless of the guard build.
    always_comb begin
        depth_nxt = depth;
        if (is_push && depth != CAP)
            depth_nxt = depth + 5'd1;
        else if (is_pop && depth != '0)
            depth_nxt = depth - 5'd1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_EMPTY: if (is_pop) state_d = RSP_FULL;
            RSP_FULL:  if (rsp_ready && !is_pop) state_d = RSP_EMPTY;
            default:   state_d = RSP_EMPTY;
        endcase
    end

    // err_clr rebases the mark to current depth; a larger next depth still wins.
    assign hwm_base = err_clr ? depth : hwm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RSP_EMPTY;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            depth     <= '0;
            hwm       <= '0;
            err_over  <= 1'b0;
            err_under <= 1'b0;
        end else begin
            state_q <= state_d;
            depth   <= depth_nxt;
            hwm     <= (depth_nxt > hwm_base) ? depth_nxt : hwm_base;
            if (is_pop) begin
                rsp_data <= underflow ? '0 : st_rd;
                rsp_err  <= underflow;
            end
            if (overflow)
                err_over <= 1'b1;
            else if (err_clr)
                err_over <= 1'b0;
            if (underflow)
                err_under <= 1'b1;
            else if (err_clr)
                err_under <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_ctl.sv
// Directed bench for stack_ctl with a behavioural LIFO behind the strobe interface.
module tb_stack_ctl;

`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  cmd_op, st_delta;
    logic [15:0] cmd_data, rsp_data, st_wd, st_rd;
    logic        st_we, err_over, err_under, err_clr;
    logic [4:0]  depth, hwm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stack_ctl #(.DEPTH(18)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .st_we(st_we), .st_delta(st_delta), .st_wd(st_wd), .st_rd(st_rd),
        .depth(depth), .hwm(hwm), .err_over(err_over), .err_under(err_under), .err_clr(err_clr)
    );

    // LIFO model: sp indexes the head entry, mem[0] is the bottom slot.
    logic [15:0] mem [0:63];
    int sp = 0;
    initial for (int i = 0; i < 64; i++) mem[i] = '0;
    assign st_rd = mem[sp];
    always @(posedge clk) begin
        if (st_delta == 2'b01) begin
            if (sp < 63) begin
                mem[sp + 1] <= st_wd;
                sp <= sp + 1;
            end
        end else if (st_delta == 2'b11) begin
            if (sp > 0) sp <= sp - 1;
        end else if (st_we) begin
            mem[sp] <= st_wd;
        end
    end

    typedef struct {
        logic v; logic [1:0] op; logic [15:0] d; logic rr; logic clr;
        logic rdy; logic we; logic [1:0] dl; logic [15:0] wd;
        logic [4:0] dep; logic [4:0] hw; logic rv; logic [15:0] rd; logic re; logic eo; logic eu;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d,
                         input logic rr, input logic clr);
        cmd_valid = v; cmd_op = op; cmd_data = d; rsp_ready = rr; err_clr = clr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Strobes must stay low while reset is held, even with a PUSH offered.
        reset = 1'b1;
        drive(1'b1, 2'b01, 16'hBEEF, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("rst_we", st_we, 0);
        check("rst_delta", st_delta, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
        #1;
        check("rst_depth", depth, 0);
        check("rst_hwm", hwm, 0);
        check("rst_rv", rsp_valid, 0);
        check("rst_rd", rsp_data, 0);
        check("rst_re", rsp_err, 0);
        check("rst_eo", err_over, 0);
        check("rst_eu", err_under, 0);

        //           v  op     d        rr clr | rdy we  dl    wd                       | dep hw rv rd       re eo eu
        vecs[0]  = '{1, 2'b01, 16'h1111, 0, 0,   1, 1, 2'b01, 16'h1111,                  1, 1, 0, 16'h0,    0, 0, 0};
        vecs[1]  = '{1, 2'b01, 16'h2222, 0, 0,   1, 1, 2'b01, 16'h2222,                  2, 2, 0, 16'h0,    0, 0, 0};
        vecs[2]  = '{1, 2'b01, 16'h3333, 0, 0,   1, 1, 2'b01, 16'h3333,                  3, 3, 0, 16'h0,    0, 0, 0};
        vecs[3]  = '{1, 2'b10, 16'h0,    1, 0,   1, 0, 2'b11, 16'h0,                     2, 3, 1, 16'h3333, 0, 0, 0};
        vecs[4]  = '{0, 2'b00, 16'h0,    1, 0,   1, 0, 2'b00, 16'h0,                     2, 3, 0, 16'h0,    0, 0, 0};
        vecs[5]  = '{1, 2'b10, 16'h0,    0, 0,   1, 0, 2'b11, 16'h0,                     1, 3, 1, 16'h2222, 0, 0, 0};
        vecs[6]  = '{1, 2'b10, 16'h0,    0, 0,   0, 0, 2'b00, 16'h0,                     1, 3, 1, 16'h2222, 0, 0, 0};
        vecs[7]  = '{1, 2'b10, 16'h0,    0, 0,   0, 0, 2'b00, 16'h0,                     1, 3, 1, 16'h2222, 0, 0, 0};
        vecs[8]  = '{1, 2'b10, 16'h0,    0, 0,   0, 0, 2'b00, 16'h0,                     1, 3, 1, 16'h2222, 0, 0, 0};
        vecs[9]  = '{1, 2'b10, 16'h0,    1, 0,   1, 0, 2'b11, 16'h0,                     0, 3, 1, 16'h1111, 0, 0, 0};
        vecs[10] = '{0, 2'b00, 16'h0,    1, 0,   1, 0, 2'b00, 16'h0,                     0, 3, 0, 16'h0,    0, 0, 0};
        vecs[11] = '{1, 2'b10, 16'h0,    0, 0,   1, 0, GUARD ? 2'b00 : 2'b11, 16'h0,     0, 3, 1, 16'h0,    1, 0, 1};
        vecs[12] = '{0, 2'b00, 16'h0,    1, 0,   1, 0, 2'b00, 16'h0,                     0, 3, 0, 16'h0,    0, 0, 1};
        vecs[13] = '{1, 2'b11, 16'hABCD, 0, 0,   1, !GUARD, 2'b00, GUARD ? 16'h0 : 16'hABCD, 0, 3, 0, 16'h0, 0, 0, 1};
        vecs[14] = '{0, 2'b00, 16'h0,    0, 1,   1, 0, 2'b00, 16'h0,                     0, 0, 0, 16'h0,    0, 0, 0};
        vecs[15] = '{1, 2'b01, 16'h5555, 0, 0,   1, 1, 2'b01, 16'h5555,                  1, 1, 0, 16'h0,    0, 0, 0};
        vecs[16] = '{1, 2'b11, 16'h6666, 0, 0,   1, 1, 2'b00, 16'h6666,                  1, 1, 0, 16'h0,    0, 0, 0};
        vecs[17] = '{1, 2'b10, 16'h0,    0, 0,   1, 0, 2'b11, 16'h0,                     0, 1, 1, 16'h6666, 0, 0, 0};
        vecs[18] = '{0, 2'b00, 16'h0,    1, 0,   1, 0, 2'b00, 16'h0,                     0, 1, 0, 16'h0,    0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].d, vecs[i].rr, vecs[i].clr);
            #1;
            check($sformatf("v%0d_rdy", i), cmd_ready, vecs[i].rdy);
            check($sformatf("v%0d_we", i), st_we, vecs[i].we);
            check($sformatf("v%0d_delta", i), st_delta, vecs[i].dl);
            check($sformatf("v%0d_wd", i), st_wd, vecs[i].wd);
            @(posedge clk); #1;
            check($sformatf("v%0d_depth", i), depth, vecs[i].dep);
            check($sformatf("v%0d_hwm", i), hwm, vecs[i].hw);
            check($sformatf("v%0d_rv", i), rsp_valid, vecs[i].rv);
            if (vecs[i].rv) begin
                check($sformatf("v%0d_rdata", i), rsp_data, vecs[i].rd);
                check($sformatf("v%0d_rerr", i), rsp_err, vecs[i].re);
            end
            check($sformatf("v%0d_eo", i), err_over, vecs[i].eo);
            check($sformatf("v%0d_eu", i), err_under, vecs[i].eu);
        end

        // Twenty pushes from empty: the last one overflows a capacity of 19.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 2'b01, 16'h1000 + 16'(k), 1'b0, 1'b0);
            #1;
            if (k == 19) begin
                check("ovf_we", st_we, !GUARD);
                check("ovf_delta", st_delta, GUARD ? 2'b00 : 2'b01);
            end
            @(posedge clk); #1;
            check($sformatf("fill%0d_depth", k), depth, (k < 19) ? k + 1 : 19);
            check($sformatf("fill%0d_eo", k), err_over, (k == 19));
        end
        check("ovf_hwm", hwm, 19);
        drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("clr_eo", err_over, 0);
        check("clr_eu", err_under, 0);
        check("clr_hwm", hwm, 19);
        check("clr_depth", depth, 19);

        // Reset while a response is pending at depth 5.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 2'b01, 16'h2000 + 16'(k), 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b1, 2'b10, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_rv", rsp_valid, 1);
        check("pre_rst_depth", depth, 5);
        check("pre_rst_rdata", rsp_data, 16'h2005);
        reset = 1'b1;
        drive(1'b1, 2'b01, 16'h7777, 1'b1, 1'b0);
        #1;
        check("mid_rst_we", st_we, 0);
        check("mid_rst_delta", st_delta, 0);
        check("mid_rst_wd", st_wd, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 2'b00, 16'h0, 1'b0, 1'b0);
        #1;
        check("post_rst_rv", rsp_valid, 0);
        check("post_rst_depth", depth, 0);
        check("post_rst_hwm", hwm, 0);
        check("post_rst_rdata", rsp_data, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
